// File: rtl/clkmux_cfg_loader_if.sv
// Serial configuration handshake between a frame source and the clock-mux config loader.
// The source drives the request/data side; the loader returns status.
interface clkmux_cfg_loader_if;
  logic cfg_start;
  logic cfg_abort;
  logic sdi;
  logic sdi_vld;
  logic busy;
  logic done;
  logic perr;

  modport master (
    output cfg_start,
    output cfg_abort,
    output sdi,
    output sdi_vld,
    input  busy,
    input  done,
    input  perr
  );

  modport slave (
    input  cfg_start,
    input  cfg_abort,
    input  sdi,
    input  sdi_vld,
    output busy,
    output done,
    output perr
  );
endinterface

// File: rtl/clkmux_cfg_loader.sv
// Serial, even-parity-checked configuration loader for a 12:1 global clock-mux cell.
// A good frame is committed to cbit/cbitb/cenb only while prog isolates the mux output.
module clkmux_cfg_loader #(
  parameter int unsigned NCBIT    = 6,
  parameter int unsigned PROG_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rstb,
  clkmux_cfg_loader_if.slave   cfg,
  output logic                 prog,
  output logic [NCBIT-1:0]     cbit,
  output logic [NCBIT-1:0]     cbitb,
  output logic                 cenb
);

  localparam int unsigned FRAME = NCBIT + 2;
  localparam int unsigned CntW  = $clog2(FRAME);
  localparam int unsigned PcntW = $clog2(PROG_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StProg,
    StDone
  } state_e;

  state_e           state_q;
  logic [FRAME-1:0] shadow_q;
  logic [CntW-1:0]  cnt_q;
  logic [PcntW-1:0] pcnt_q;
  logic             busy_q;
  logic             done_q;
  logic             perr_q;

  assign cfg.busy = busy_q;
  assign cfg.done = done_q;
  assign cfg.perr = perr_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      prog     <= 1'b0;
      cbit     <= '0;
      cbitb    <= '1;
      cenb     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg.cfg_start) begin
            state_q <= StShift;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          // Abort wins over a bit arriving in the same cycle.
          if (cfg.cfg_abort) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cfg.sdi_vld) begin
            shadow_q[cnt_q] <= cfg.sdi;
            if (cnt_q == CntW'(FRAME - 1)) begin
              state_q <= StCheck;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StCheck: begin
          if (^shadow_q == 1'b0) begin
            state_q <= StProg;
            pcnt_q  <= '0;
            prog    <= 1'b1;
          end else begin
            state_q <= StIdle;
            perr_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StProg: begin
          // Load at the end of p=1 so prog brackets the select change on both sides.
          if (pcnt_q == PcntW'(1)) begin
            cbit  <= shadow_q[NCBIT-1:0];
            cbitb <= ~shadow_q[NCBIT-1:0];
            cenb  <= shadow_q[NCBIT];
          end
          if (pcnt_q == PcntW'(PROG_CYC - 1)) begin
            state_q <= StDone;
            pcnt_q  <= '0;
            prog    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkmux_cfg_loader.sv
// Directed self-checking bench for clkmux_cfg_loader with hand-computed expectations.
// Cycle T+k is sampled on the falling edge after rising edge T+k-1; T is the edge sampling cfg_start.
module tb_clkmux_cfg_loader;

  logic       clk;
  logic       rstb;
  logic       prog;
  logic [5:0] cbit;
  logic [5:0] cbitb;
  logic       cenb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  int at     = 0;
  bit seen_prog;
  bit seen_done;

  clkmux_cfg_loader_if cfg_if ();

  clkmux_cfg_loader #(
    .NCBIT    (6),
    .PROG_CYC (4)
  ) dut (
    .clk   (clk),
    .rstb  (rstb),
    .cfg   (cfg_if),
    .prog  (prog),
    .cbit  (cbit),
    .cbitb (cbitb),
    .cenb  (cenb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Pulse cfg_start for one edge; afterwards the bench sits in cycle T+1.
  task automatic start();
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic send_bits(input logic [7:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cfg_if.sdi     = f[i];
      cfg_if.sdi_vld = 1'b1;
      tick();
    end
    cfg_if.sdi_vld = 1'b0;
  endtask

  // Returns the cycle (relative to T) in which done is seen, or -1 on timeout.
  task automatic wait_done(output int when);
    when = -1;
    for (int i = 0; i < 40; i++) begin
      if (cfg_if.done === 1'b1) begin
        when = cyc - t0;
        break;
      end
      tick();
    end
  endtask

  initial begin
    rstb             = 1'b1;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_abort = 1'b0;
    cfg_if.sdi       = 1'b0;
    cfg_if.sdi_vld   = 1'b0;
    #1 rstb = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_cbit", cbit, 6'h00);
    chk("rst_cbitb", cbitb, 6'h3F);
    chk("rst_cenb", cenb, 1'b1);
    chk("rst_prog", prog, 1'b0);
    chk("rst_busy", cfg_if.busy, 1'b0);
    chk("rst_done", cfg_if.done, 1'b0);
    chk("rst_perr", cfg_if.perr, 1'b0);
    rstb = 1'b1;
    tick();

    // Good frame 0x1D (cbit=1D, cenb=0, parity=0); stray start in SHIFT, abort in PROG
    start();
    chk("t1_busy", cfg_if.busy, 1'b1);
    send_bits(8'h1D, 0, 2);
    cfg_if.cfg_start = 1'b1;
    send_bits(8'h1D, 3, 3);
    cfg_if.cfg_start = 1'b0;
    send_bits(8'h1D, 4, 7);
    chk("t9_prog", prog, 1'b0);
    chk("t9_busy", cfg_if.busy, 1'b1);
    tick();
    chk("t10_prog", prog, 1'b1);
    chk("t10_cbit_old", cbit, 6'h00);
    cfg_if.cfg_abort = 1'b1;
    tick();
    cfg_if.cfg_abort = 1'b0;
    chk("t11_prog", prog, 1'b1);
    chk("t11_cenb_old", cenb, 1'b1);
    tick();
    chk("t12_prog", prog, 1'b1);
    chk("t12_cbit", cbit, 6'h1D);
    chk("t12_cbitb", cbitb, 6'h22);
    chk("t12_cenb", cenb, 1'b0);
    tick();
    chk("t13_prog", prog, 1'b1);
    chk("t13_done", cfg_if.done, 1'b0);
    tick();
    chk("t14_done", cfg_if.done, 1'b1);
    chk("t14_prog", prog, 1'b0);
    chk("t14_busy", cfg_if.busy, 1'b0);
    chk("t14_perr", cfg_if.perr, 1'b0);
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    chk("t15_done", cfg_if.done, 1'b0);
    chk("t15_busy", cfg_if.busy, 1'b0);
    tick();
    chk("start_in_done_ignored", cfg_if.busy, 1'b0);

    // Parity flipped: 0x9D
    start();
    send_bits(8'h9D, 0, 7);
    tick();
    chk("perr_set", cfg_if.perr, 1'b1);
    chk("perr_busy", cfg_if.busy, 1'b0);
    seen_prog = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (prog === 1'b1) seen_prog = 1'b1;
      if (cfg_if.done === 1'b1) seen_done = 1'b1;
      tick();
    end
    chk("perr_no_prog", seen_prog, 1'b0);
    chk("perr_no_done", seen_done, 1'b0);
    chk("perr_cbit_kept", cbit, 6'h1D);
    chk("perr_cenb_kept", cenb, 1'b0);

    // Next start clears perr; frame 0x6A (cbit=2A, cenb=1) with a 5-cycle stall after bit 3
    start();
    chk("perr_cleared", cfg_if.perr, 1'b0);
    send_bits(8'h6A, 0, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_busy", cfg_if.busy, 1'b1);
    send_bits(8'h6A, 4, 7);
    wait_done(at);
    chk("stall_done_cycle", at, 19);
    chk("stall_cbit", cbit, 6'h2A);
    chk("stall_cbitb", cbitb, 6'h15);
    chk("stall_cenb", cenb, 1'b1);
    chk("stall_perr", cfg_if.perr, 1'b0);
    tick();
    tick();

    // Abort after 4 bits, with a valid bit in the same cycle
    start();
    send_bits(8'h1D, 0, 3);
    cfg_if.cfg_abort = 1'b1;
    cfg_if.sdi_vld   = 1'b1;
    cfg_if.sdi       = 1'b1;
    tick();
    cfg_if.cfg_abort = 1'b0;
    cfg_if.sdi_vld   = 1'b0;
    chk("abort_busy", cfg_if.busy, 1'b0);
    seen_prog = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (prog === 1'b1) seen_prog = 1'b1;
      if (cfg_if.done === 1'b1) seen_done = 1'b1;
      tick();
    end
    chk("abort_no_prog", seen_prog, 1'b0);
    chk("abort_no_done", seen_done, 1'b0);
    chk("abort_cbit_kept", cbit, 6'h2A);
    chk("abort_perr", cfg_if.perr, 1'b0);

    // Full frame after abort commits normally
    start();
    send_bits(8'h1D, 0, 7);
    wait_done(at);
    chk("post_abort_done_cycle", at, 14);
    chk("post_abort_cbit", cbit, 6'h1D);
    chk("post_abort_cenb", cenb, 1'b0);
    tick();
    tick();

    // Reset during PROG p=0
    start();
    send_bits(8'h6A, 0, 7);
    tick();
    chk("rstp_prog_before", prog, 1'b1);
    #2 rstb = 1'b0;
    #1;
    chk("rstp_prog", prog, 1'b0);
    chk("rstp_cbit", cbit, 6'h00);
    chk("rstp_cbitb", cbitb, 6'h3F);
    chk("rstp_cenb", cenb, 1'b1);
    chk("rstp_busy", cfg_if.busy, 1'b0);
    tick();
    rstb = 1'b1;
    tick();
    start();
    chk("rstp_idle_accepts_start", cfg_if.busy, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkmux_cfg_loader.md
Name: clkmux_cfg_loader

Overview:
- Serial configuration loader for one global clock-mux cell (12:1 clock mux with enable latch).
- Sits directly upstream of the mux and drives its complementary select bits cbit/cbitb, clock-enable cenb and isolation signal prog.
- Receives a parity-protected serial frame and checks it.
- Commits a good frame only inside a prog window, so the mux output is held quiet while selects change.

Parameters:
- NCBIT, 6, number of mux configuration bits (cbit[3:0] input select, cbit[4] output enable, cbit[5] invert-select).
- PROG_CYC, 4, cycles prog is held high per commit; legal minimum 3.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rstb  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- cfg_abort  input  1  discards a frame in progress; honoured only in SHIFT.
- sdi  input  1  serial frame data, LSB first.
- sdi_vld  input  1  qualifies sdi; a bit is captured only when high in SHIFT.
- busy  output  1  high in SHIFT, CHECK, PROG.
- done  output  1  one-cycle pulse after a successful commit.
- perr  output  1  sticky parity error; cleared by next accepted cfg_start.
- prog  output  1  mux isolation, high only in PROG.
- cbit  output  NCBIT  committed configuration, true polarity.
- cbitb  output  NCBIT  committed configuration, complement.
- cenb  output  1  committed clock-enable, active low.

Behaviour:
- Frame format: FRAME = NCBIT+2 bits, LSB first.
  - Bits 0..NCBIT-1 are cbit[0..NCBIT-1].
  - Bit NCBIT is cenb.
  - Bit NCBIT+1 is the parity bit; the XOR over all FRAME bits must be 0 (even parity).
- Reset (rstb low, asynchronous), state IDLE:
  - cbit=0, cbitb=all 1s, cenb=1, prog=0, busy=0, done=0, perr=0.
  - Shadow register and counters are 0.
- cbit and cbitb are each driven from their own flops, loaded on the same edge.
  - cbitb == ~cbit at all times, including during reset.
- FSM states: IDLE, SHIFT, CHECK, PROG, DONE.
- IDLE:
  - cfg_start=1 -> SHIFT; bit counter=0; perr cleared.
- SHIFT:
  - On each cycle with sdi_vld=1: shadow[cnt]<=sdi, cnt++.
  - sdi_vld=0 stalls indefinitely; there is no timeout.
  - Capture of bit FRAME-1 -> CHECK.
  - cfg_abort=1 -> IDLE; shadow discarded; outputs unchanged; done/perr not asserted. cfg_abort takes priority over a bit captured in the same cycle.
  - cfg_start is ignored.
- CHECK, one cycle:
  - Parity OK -> PROG, prog counter=0.
  - Parity bad -> perr<=1, -> IDLE; committed outputs unchanged.
- PROG, exactly PROG_CYC cycles, p=0..PROG_CYC-1, with prog=1:
  - cbit/cbitb/cenb load from shadow at the end of p=1, so prog is high for ≥1 cycle before and ≥1 cycle after the change.
  - After p=PROG_CYC-1 -> DONE.
  - cfg_start and cfg_abort are ignored.
- DONE, one cycle:
  - done=1, busy=0 -> IDLE.
  - A cfg_start in this cycle is ignored.
- Latency with continuous sdi_vld and cfg_start sampled at edge T:
  - SHIFT T+1..T+FRAME.
  - CHECK T+FRAME+1.
  - prog high T+FRAME+2..T+FRAME+1+PROG_CYC.
  - done at T+FRAME+2+PROG_CYC.
  - Defaults: prog cycles T+10..T+13, outputs change visible at T+12, done at T+14.
- Reset asserted mid-frame or mid-PROG:
  - Immediate return to reset values, prog drops asynchronously.
  - No partial commit.
- No output is combinationally derived from inputs; all outputs are registered.

Test Plan:
- Reset -> cbit=6'h00, cbitb=6'h3F, cenb=1, prog=0, busy=0, done=0, perr=0.
- Pulse cfg_start, stream bits 1,0,1,1,1,0 (cbit=6'h1D), cenb=0, parity=0 with sdi_vld always 1:
  - prog high cycles T+10..T+13.
  - cbit=6'h1D, cbitb=6'h22, cenb=0 from T+12.
  - done pulse at T+14, perr=0.
- Same frame with the parity bit flipped:
  - perr=1, prog never rises, outputs keep prior values, busy low after CHECK.
  - Next cfg_start clears perr.
- sdi_vld low for 5 cycles after bit 3:
  - counter holds and the frame completes correctly.
  - done is 5 cycles later than in the continuous case.
- cfg_abort after 4 bits:
  - back to IDLE, no prog, no done, outputs unchanged.
  - A new full frame afterwards commits normally.
- Deassert rstb during PROG cycle p=0:
  - prog drops immediately, cbit=0, cbitb=6'h3F, cenb=1, state IDLE.
  - cfg_start pulses during busy and in DONE are ignored.
